uart_rx_flow_fifo: RTL and testbench

//  Receive-side byte FIFO that sits between uart_rx and the AXIS consumer.

---
 rtl/uart_rx_flow_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_flow_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_flow_fifo.sv
// Receive-side byte FIFO between uart_rx and an AXI-Stream consumer, with
// fill-level driven cts_n hysteresis and sticky overflow / drop accounting.
module uart_rx_flow_fifo #(
  parameter int DEPTH        = 64,
  parameter int STOP_LEVEL   = DEPTH - 16,
  parameter int RESUME_LEVEL = DEPTH / 2
) (
  input  logic                       clk,
  input  logic                       sreset,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [7:0]                 m_axis_tdata,
  output logic                       cts_n,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  input  logic                       clear_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_L   = LW'(DEPTH);
  localparam logic [LW-1:0] STOP_L   = LW'(STOP_LEVEL);
  localparam logic [LW-1:0] RESUME_L = LW'(RESUME_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          cts_n_reg;
  logic          overflow_reg;
  logic [15:0]   drop_count_reg;
  logic          push_ok;
  logic          drop;
  logic          pop;

  // Full test uses the pre-edge level, so a same-cycle pop never rescues a push.
  always_comb begin
    push_ok    = s_valid && (level_reg != FULL_L);
    drop       = s_valid && (level_reg == FULL_L);
    pop        = (level_reg != '0) && m_axis_tready;
    level_next = level_reg + {{(LW-1){1'b0}}, push_ok} - {{(LW-1){1'b0}}, pop};
  end

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      cts_n_reg      <= 1'b1;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;

      // Between the two thresholds cts_n keeps its previous value.
      if (level_next >= STOP_L) begin
        cts_n_reg <= 1'b1;
      end else if (level_next <= RESUME_L) begin
        cts_n_reg <= 1'b0;
      end

      // A drop coinciding with a clear is counted after the clear.
      if (clear_status) begin
        overflow_reg   <= drop;
        drop_count_reg <= {15'd0, drop};
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
    end
  end

  assign m_axis_tvalid = (level_reg != '0);
  assign m_axis_tdata  = mem[rd_ptr_reg];
  assign cts_n         = cts_n_reg;
  assign level         = level_reg;
  assign overflow      = overflow_reg;
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_uart_rx_flow_fifo.sv
// Bench for uart_rx_flow_fifo: directed scenarios plus a randomized stream,
// every cycle compared against a queue-based reference model.
module tb_uart_rx_flow_fifo;

  localparam int DEPTH  = 64;
  localparam int STOP   = DEPTH - 16;
  localparam int RESUME = DEPTH / 2;

  logic        clk = 1'b0;
  logic        sreset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        cts_n;
  logic [6:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_status = 1'b0;

  uart_rx_flow_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .sreset        (sreset),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .cts_n         (cts_n),
    .level         (level),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clear_status  (clear_status)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  bit         m_cts = 1'b1;
  bit         m_ovf = 1'b0;
  int         m_dc  = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare current outputs with the model, apply inputs for one edge, advance the model.
  task automatic cyc(input bit rst, input bit sv, input logic [7:0] sd, input bit rdy, input bit clr);
    bit full;
    bit drop;
    logic [7:0] b;
    check("tvalid", int'(m_axis_tvalid), int'(q.size() != 0));
    if (q.size() != 0) check("tdata", int'(m_axis_tdata), int'(q[0]));
    check("level", int'(level), q.size());
    check("cts_n", int'(cts_n), int'(m_cts));
    check("overflow", int'(overflow), int'(m_ovf));
    check("drop_count", int'(drop_count), m_dc);
    sreset = rst; s_valid = sv; s_data = sd; m_axis_tready = rdy; clear_status = clr;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cts = 1'b1;
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      full = (q.size() == DEPTH);
      drop = sv && full;
      if (rdy && q.size() != 0) begin
        b = q.pop_front();
        $display("pop  0x%02h level %0d", b, q.size());
      end
      if (sv && !full) q.push_back(sd);
      if (drop) $display("drop 0x%02h", sd);
      if (q.size() >= STOP) m_cts = 1'b1;
      else if (q.size() <= RESUME) m_cts = 1'b0;
      if (clr) begin
        m_ovf = drop;
        m_dc  = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
    end
    #1;
  endtask

  task automatic push_n(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 1, 8'($urandom), rdy, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 1, 0);
  endtask

  initial begin
    int pushed;
    bit sv;
    @(posedge clk);
    #1;
    // Reset state
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'h77, 1, 0);
    check("cts_in_reset", int'(cts_n), 1);
    cyc(0, 0, 8'h00, 0, 0);
    check("cts_after_release", int'(cts_n), 0);

    // Three bytes held, then streamed out
    cyc(0, 1, 8'h11, 0, 0);
    cyc(0, 1, 8'h22, 0, 0);
    cyc(0, 1, 8'h33, 0, 0);
    check("three_level", int'(level), 3);
    check("three_head", int'(m_axis_tdata), 8'h11);
    pop_n(4);

    // cts_n hysteresis
    push_n(48, 0);
    check("cts_stop", int'(cts_n), 1);
    pop_n(15);
    check("cts_band", int'(cts_n), 1);
    pop_n(1);
    check("cts_resume", int'(cts_n), 0);
    pop_n(33);

    // Full FIFO: a push with a same-cycle pop is still dropped
    push_n(64, 0);
    cyc(0, 1, 8'hAA, 1, 0);
    check("full_drop_level", int'(level), 63);
    check("full_drop_count", int'(drop_count), 1);
    pop_n(64);
    cyc(0, 0, 8'h00, 0, 1);

    // Six overflow bytes, then clear colliding with a drop
    push_n(70, 0);
    check("drops_six", int'(drop_count), 6);
    cyc(0, 1, 8'hEE, 0, 1);
    check("clear_drop_count", int'(drop_count), 1);
    check("clear_drop_ovf", int'(overflow), 1);
    pop_n(44);

    // Reset mid-stream at level 20
    cyc(1, 0, 8'h00, 0, 0);
    check("rst_level", int'(level), 0);
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h5A, 0, 0);
    check("post_rst_head", int'(m_axis_tdata), 8'h5A);
    pop_n(2);

    // Randomized wrap-around stream
    pushed = 0;
    for (int t = 0; t < 4000 && pushed < 200; t++) begin
      sv = ($urandom_range(0, 1) == 1) && (q.size() < 60);
      cyc(0, sv, 8'($urandom), bit'($urandom_range(0, 1)), 0);
      if (sv) pushed++;
    end
    check("stream_pushed", pushed, 200);
    pop_n(64);
    check("stream_drops", int'(drop_count), 0);
    cyc(0, 0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
